pc_fetch_unit: RTL and testbench

- Program counter and instruction-fetch stage directly upstream of the microcoded control unit.
- Holds the 8-bit PC and addresses a synchronous-read program ROM (1-cycle latency).
- Supplies the fetched opcode byte, with a valid flag, to the control unit's instruction input.
- Executes the control unit's PC strobes (load, increment, drive-to-bus). Optional hardware return stack for call/return.

---
 rtl/pc_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_unit
// Brief   : 8-bit program counter and one-deep fetch stage for the control
//           unit; optional return stack enabled by defining PC_STACK_EN.
// Revision: 1.0
// ============================================================================
module pc_fetch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ctrlLoadPC,
    input  logic                  i_ctrlIncrPC,
    input  logic                  i_ctrlPCNOe,
    input  logic                  i_ctrlCall,
    input  logic                  i_ctrlRet,
    input  logic [7:0]            i_bus,
    output logic [7:0]            o_bus,
    output logic                  o_busDrive,
    output logic [ADDR_WIDTH-1:0] o_romAddr,
    input  logic [7:0]            i_romData,
    output logic [7:0]            o_instruction,
    output logic                  o_instrValid,
    output logic                  o_pcWrap,
    output logic                  o_stackErr
);

    typedef enum logic [0:0] {
        PEND = 1'b0,
        HOLD = 1'b1
    } fetchState_t;

    fetchState_t           r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pcNext;
    logic [ADDR_WIDTH-1:0] w_pcIncr;
    logic                  w_wrap;
    logic                  w_pcChange;

    assign w_pcIncr   = r_pc + ADDR_WIDTH'(1);
    assign w_pcChange = (w_pcNext != r_pc);

    assign o_romAddr  = r_pc;
    assign o_busDrive = ~i_ctrlPCNOe;
    assign o_bus      = o_busDrive ? r_pc[7:0] : 8'h00;

`ifdef PC_STACK_EN
    localparam int c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int c_SP_W  = c_IDX_W + 1;

    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [c_SP_W-1:0]     r_sp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_stackErrSet;
    logic [c_IDX_W-1:0]    w_topIdx;
    logic [c_IDX_W-1:0]    w_pushIdx;

    assign w_topIdx  = c_IDX_W'(r_sp - c_SP_W'(1));
    assign w_pushIdx = c_IDX_W'(r_sp);

    // Ret outranks Call, which outranks Load, which outranks Incr.
    always_comb begin
        w_pcNext      = r_pc;
        w_wrap        = 1'b0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_stackErrSet = 1'b0;
        if (i_ctrlRet) begin
            if (r_sp == '0) begin
                w_stackErrSet = 1'b1;
            end else begin
                w_pop    = 1'b1;
                w_pcNext = r_stack[w_topIdx];
            end
        end else if (i_ctrlCall) begin
            if (r_sp == c_SP_W'(STACK_DEPTH)) begin
                w_stackErrSet = 1'b1;
            end else begin
                w_push   = 1'b1;
                w_pcNext = ADDR_WIDTH'(i_bus);
            end
        end else if (i_ctrlLoadPC) begin
            w_pcNext = ADDR_WIDTH'(i_bus);
        end else if (i_ctrlIncrPC) begin
            w_pcNext = w_pcIncr;
            w_wrap   = &r_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sp       <= '0;
            o_stackErr <= 1'b0;
        end else begin
            if (w_push) begin
                r_sp <= r_sp + c_SP_W'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - c_SP_W'(1);
            end
            if (w_stackErrSet) begin
                o_stackErr <= 1'b1;
            end
        end
    end

    // Stack storage needs no reset; the pointer alone defines what is live.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) begin
            r_stack[w_pushIdx] <= w_pcIncr;
        end
    end
`else
    logic w_unusedStack;
    assign w_unusedStack = i_ctrlCall ^ i_ctrlRet;
    assign o_stackErr    = 1'b0;

    always_comb begin
        w_pcNext = r_pc;
        w_wrap   = 1'b0;
        if (i_ctrlLoadPC) begin
            w_pcNext = ADDR_WIDTH'(i_bus);
        end else if (i_ctrlIncrPC) begin
            w_pcNext = w_pcIncr;
            w_wrap   = &r_pc;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= '0;
            o_instruction <= 8'h00;
            o_instrValid  <= 1'b0;
            o_pcWrap      <= 1'b0;
            r_state       <= PEND;
        end else begin
            r_pc <= w_pcNext;
            if (w_wrap) begin
                o_pcWrap <= 1'b1;
            end
            case (r_state)
                // A capture is only trusted if the address stayed put across it.
                PEND: begin
                    if (!w_pcChange) begin
                        o_instruction <= i_romData;
                        o_instrValid  <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_pcChange) begin
                        o_instrValid <= 1'b0;
                        r_state      <= PEND;
                    end
                end
                default: begin
                    o_instrValid <= 1'b0;
                    r_state      <= PEND;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_fetch_unit
// Brief   : Self-checking bench for pc_fetch_unit against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_pc_fetch_unit;

    logic       clk;
    logic       rst;
    logic       ld, inc, noe, call, ret;
    logic [7:0] busIn;
    logic [7:0] busOut;
    logic       busDrive;
    logic [7:0] romAddr;
    logic [7:0] romData;
    logic [7:0] instr;
    logic       instrValid;
    logic       pcWrap;
    logic       stackErr;

    logic [7:0] rom [256];

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_ctrlLoadPC (ld),
        .i_ctrlIncrPC (inc),
        .i_ctrlPCNOe  (noe),
        .i_ctrlCall   (call),
        .i_ctrlRet    (ret),
        .i_bus        (busIn),
        .o_bus        (busOut),
        .o_busDrive   (busDrive),
        .o_romAddr    (romAddr),
        .i_romData    (romData),
        .o_instruction(instr),
        .o_instrValid (instrValid),
        .o_pcWrap     (pcWrap),
        .o_stackErr   (stackErr)
    );

    // ROM data is ready for the edge following the address.
    assign romData = rom[romAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: PC, stickies, stack as a queue, fetch as an age count.
    int  m_pc = 0, m_age = 0, m_instr = 0, m_wrap = 0, m_err = 0;
    bit  m_live = 0;
    int  m_stk [$];

    always @(posedge clk) begin
        int nxt;
        if (rst) begin
            m_pc = 0; m_age = 0; m_instr = 0; m_wrap = 0; m_err = 0;
            m_stk.delete();
        end else begin
            nxt = m_pc;
`ifdef PC_STACK_EN
            if (ret) begin
                if (m_stk.size() == 0) m_err = 1;
                else nxt = m_stk.pop_back();
            end else if (call) begin
                if (m_stk.size() == 4) m_err = 1;
                else begin
                    m_stk.push_back((m_pc + 1) % 256);
                    nxt = busIn;
                end
            end else
`endif
            if (ld) nxt = busIn;
            else if (inc) begin
                nxt = (m_pc + 1) % 256;
                if (m_pc == 255) m_wrap = 1;
            end
            if (nxt != m_pc) m_age = 0;
            else begin
                if (m_age == 0) m_instr = rom[m_pc];
                if (m_age < 2) m_age++;
            end
            m_pc = nxt;
        end
        m_live = 1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("romAddr",  romAddr,    m_pc);
            chk("valid",    instrValid, (m_age >= 1) ? 1 : 0);
            chk("instr",    instr,      m_instr);
            chk("pcWrap",   pcWrap,     m_wrap);
            chk("stackErr", stackErr,   m_err);
            chk("busDrive", busDrive,   noe ? 0 : 1);
            chk("busOut",   busOut,     noe ? 0 : m_pc);
        end
    end

    task automatic step(input logic l, input logic i, input logic n,
                        input logic c, input logic r, input logic [7:0] b);
        ld = l; inc = i; noe = n; call = c; ret = r; busIn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'(a) ^ 8'hA5;
        rom[0] = 8'h3C;
        rom[1] = 8'h91;
        rst = 1'b1; ld = 0; inc = 0; noe = 1; call = 0; ret = 0; busIn = 0;

        // The last reset edge acts as the PC change; capture follows one edge later.
        doReset();
        chk("rst_valid", instrValid, 0);
        chk("rst_instr", instr, 8'h00);
        chk("rst_addr",  romAddr, 0);
        idle();
        chk("boot_valid", instrValid, 1);
        chk("boot_instr", instr, 8'h3C);

        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("incr_addr",  romAddr, 1);
        chk("incr_valid", instrValid, 0);
        idle();
        chk("incr_valid2", instrValid, 1);
        chk("incr_instr",  instr, 8'h91);

        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        chk("load_ff", romAddr, 8'hFF);
        chk("nowrap",  pcWrap, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("wrap_addr", romAddr, 0);
        chk("wrap_flag", pcWrap, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
        chk("ld_over_inc", romAddr, 8'h40);

        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h27);
        idle();
        noe = 1'b0;
        #1;
        chk("bus_val",   busOut, 8'h27);
        chk("bus_drive", busDrive, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("bus_hold_pc", romAddr, 8'h27);
        chk("bus_hold_v",  instrValid, 1);
        chk("bus_instr",   instr, 8'h82);
        idle();
        chk("bus_off", busOut, 8'h00);

        // Incr on the capture edge discards that capture.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h50);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("race_valid", instrValid, 0);
        chk("race_instr", instr, 8'h82);
        idle();
        chk("race_valid2", instrValid, 1);
        chk("race_instr2", instr, 8'hF4);

        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h60);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("midrst_addr",  romAddr, 0);
        chk("midrst_valid", instrValid, 0);
        chk("midrst_wrap",  pcWrap, 0);

`ifdef PC_STACK_EN
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("ret_empty_pc",  romAddr, 0);
        chk("ret_empty_err", stackErr, 1);
        doReset();
        chk("err_cleared", stackErr, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80);
        chk("call_pc", romAddr, 8'h80);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
        chk("ret_pc", romAddr, 8'h11);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h20 + k));
        chk("full_pc",  romAddr, 8'h23);
        chk("full_err", stackErr, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h30);
        chk("over_pc",  romAddr, 8'h23);
        chk("over_err", stackErr, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("pop_pc", romAddr, 8'h23);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("pop_pc2", romAddr, 8'h22);
`else
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
        chk("nocall_pc", romAddr, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("noret_pc",  romAddr, 0);
        chk("noret_err", stackErr, 0);
`endif
        idle();
        idle();
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
